// File: rtl/icache_refill_arbiter_if.sv
// Shared word-wide backing-memory port between the refill arbiter (master) and memory (slave).
interface icache_refill_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/icache_refill_arbiter.sv
// Shares one memory port between 8-word I-cache line refills and single-word data accesses.
// Optional macro CRITICAL_WORD_FIRST_EN starts each burst at the missing word and wraps around the line.
module icache_refill_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int OFF_BITS   = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ic_miss,
    input  logic [31:0]         ic_addr,
    output logic                ic_stall,
    output logic                ic_fill_we,
    output logic [OFF_BITS-1:0] ic_fill_idx,
    output logic [31:0]         ic_fill_data,
    output logic                ic_fill_done,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [31:0]         dm_addr,
    input  logic [31:0]         dm_wdata,
    output logic [31:0]         dm_rdata,
    output logic                dm_ack,
    icache_refill_arbiter_if.master mem
);

    typedef enum logic [1:0] {IDLE, IC_FILL, IC_DONE, DM_ACC} state_t;
    typedef enum logic {GRANT_IC, GRANT_DM} grant_t;

    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    state_t              state, state_next;
    grant_t              last_grant, last_grant_next;
    logic [OFF_BITS-1:0] cnt, cnt_next;
    logic [OFF_BITS-1:0] beats, beats_next;
    logic [OFF_BITS-1:0] start_word;
    logic                unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_word = ic_addr[OFF_BITS+1:2];
`else
    assign start_word = '0;
`endif

    assign unused_addr_bits = ^ic_addr[OFF_BITS+1:0];

    assign ic_stall = ic_miss | (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            beats      <= '0;
            last_grant <= GRANT_IC;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            beats      <= beats_next;
            last_grant <= last_grant_next;
        end
    end

    // cnt addresses the word slot and may start mid-line; beats counts transfers so the burst always ends after a full line.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        beats_next      = beats;
        last_grant_next = last_grant;
        mem.req         = 1'b0;
        mem.we          = 1'b0;
        mem.addr        = '0;
        mem.wdata       = '0;
        ic_fill_we      = 1'b0;
        ic_fill_idx     = '0;
        ic_fill_data    = '0;
        ic_fill_done    = 1'b0;
        dm_ack          = 1'b0;
        dm_rdata        = '0;

        unique case (state)
            IDLE: begin
                if (ic_miss && (!dm_req || last_grant == GRANT_DM)) begin
                    state_next = IC_FILL;
                    cnt_next   = start_word;
                    beats_next = '0;
                end else if (dm_req) begin
                    state_next = DM_ACC;
                end
            end
            IC_FILL: begin
                mem.req  = 1'b1;
                mem.addr = {ic_addr[31:OFF_BITS+2], cnt, 2'b00};
                if (mem.ack) begin
                    ic_fill_we   = 1'b1;
                    ic_fill_idx  = cnt;
                    ic_fill_data = mem.rdata;
                    cnt_next     = cnt + 1'b1;
                    beats_next   = beats + 1'b1;
                    if (beats == LAST_BEAT) begin
                        state_next      = IC_DONE;
                        last_grant_next = GRANT_IC;
                    end
                end
            end
            IC_DONE: begin
                ic_fill_done = 1'b1;
                state_next   = IDLE;
            end
            DM_ACC: begin
                mem.req   = 1'b1;
                mem.we    = dm_we;
                mem.addr  = dm_addr;
                mem.wdata = dm_wdata;
                if (mem.ack) begin
                    dm_ack          = 1'b1;
                    dm_rdata        = mem.rdata;
                    state_next      = IDLE;
                    last_grant_next = GRANT_DM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed table-driven bench for icache_refill_arbiter with a latency-programmable memory responder.
module tb_icache_refill_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ic_miss;
    logic [31:0] ic_addr;
    logic        ic_stall;
    logic        ic_fill_we;
    logic [2:0]  ic_fill_idx;
    logic [31:0] ic_fill_data;
    logic        ic_fill_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    int checks = 0;
    int errors = 0;

    int lat_mode = 1;
    bit stray_en = 1'b0;
    int cur_lat  = 1;
    int wait_cnt = 0;
    logic [31:0] mem_store [logic [31:0]];

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct {
        logic        miss;
        logic [31:0] ic_addr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          dm_delay;
        int          lat;
        bit          stray;
        logic [2:0]  first_idx;
        int          done_rel;
        int          dm_rel;
        bit          dm_first;
        logic [31:0] rdata;
    } vec_t;

    icache_refill_arbiter_if mem_bus ();

    icache_refill_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .ic_miss      (ic_miss),
        .ic_addr      (ic_addr),
        .ic_stall     (ic_stall),
        .ic_fill_we   (ic_fill_we),
        .ic_fill_idx  (ic_fill_idx),
        .ic_fill_data (ic_fill_data),
        .ic_fill_done (ic_fill_done),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ack       (dm_ack),
        .mem          (mem_bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory responder: acks after cur_lat cycles of a held request, optionally fires stray acks while idle.
    always @(negedge CLK) begin
        if (mem_bus.req) begin
            if (wait_cnt == 0) cur_lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 5));
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= cur_lat) begin
                mem_bus.ack   = 1'b1;
                mem_bus.rdata = mem_read(mem_bus.addr);
                if (mem_bus.we) mem_store[mem_bus.addr] = mem_bus.wdata;
                wait_cnt = 0;
            end else begin
                mem_bus.ack   = 1'b0;
                mem_bus.rdata = 32'h0;
            end
        end else begin
            wait_cnt      = 0;
            mem_bus.ack   = stray_en && ($urandom_range(0, 2) == 0);
            mem_bus.rdata = mem_bus.ack ? 32'hBAD0_0000 | $urandom_range(0, 65535) : 32'h0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_mem_req"},   32'(mem_bus.req),   32'd0);
        check_output({tag, "_mem_we"},    32'(mem_bus.we),    32'd0);
        check_output({tag, "_mem_addr"},  mem_bus.addr,       32'd0);
        check_output({tag, "_mem_wdata"}, mem_bus.wdata,      32'd0);
        check_output({tag, "_stall"},     32'(ic_stall),      32'd0);
        check_output({tag, "_fill_we"},   32'(ic_fill_we),    32'd0);
        check_output({tag, "_fill_idx"},  32'(ic_fill_idx),   32'd0);
        check_output({tag, "_fill_data"}, ic_fill_data,       32'd0);
        check_output({tag, "_done"},      32'(ic_fill_done),  32'd0);
        check_output({tag, "_dm_ack"},    32'(dm_ack),        32'd0);
        check_output({tag, "_dm_rdata"},  dm_rdata,           32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        ic_miss  = v.miss;
        ic_addr  = v.ic_addr;
        dm_we    = v.dwe;
        dm_addr  = v.daddr;
        dm_wdata = v.dwdata;
        dm_req   = v.dreq && (v.dm_delay == 0);
        lat_mode = v.lat;
        stray_en = v.stray;
    endtask

    // Called at posedge+2; runs one vector to completion and compares everything it observes.
    task automatic run_vector(input int n, input vec_t v);
        int          fills = 0;
        int          dm_rel = 0;
        int          done_rel = 0;
        int          c = 0;
        bit          dm_raised;
        bit          finished = 1'b0;
        logic [2:0]  idx_exp;
        logic [31:0] addr_exp;
        logic        p_req = 1'b0;
        logic        p_ack = 1'b0;
        logic        p_we = 1'b0;
        logic [31:0] p_addr = '0;
        logic [31:0] p_wdata = '0;
        string       tag;
        tag = $sformatf("v%0d", n);
        apply_stimulus(v);
        dm_raised = v.dreq && (v.dm_delay == 0);
        idx_exp   = v.first_idx;
        while (!finished && c < 150) begin
            c++;
            @(negedge CLK);
            #1;
            if (c == 1) check_output({tag, "_stall_first"}, 32'(ic_stall), 32'(v.miss));
            if (p_req && !p_ack && mem_bus.req) begin
                check_output({tag, "_hold_addr"},  mem_bus.addr,  p_addr);
                check_output({tag, "_hold_we"},    32'(mem_bus.we), 32'(p_we));
                check_output({tag, "_hold_wdata"}, mem_bus.wdata, p_wdata);
            end
            if (ic_fill_we) begin
                fills++;
                addr_exp = {v.ic_addr[31:5], idx_exp, 2'b00};
                check_output({tag, "_fill_idx"},  32'(ic_fill_idx), 32'(idx_exp));
                check_output({tag, "_fill_addr"}, mem_bus.addr,     addr_exp);
                check_output({tag, "_fill_data"}, ic_fill_data,     mem_read(addr_exp));
                check_output({tag, "_fill_mwe"},  32'(mem_bus.we),  32'd0);
                idx_exp = idx_exp + 3'd1;
            end
            if (dm_ack) begin
                dm_rel = c;
                check_output({tag, "_dm_addr"}, mem_bus.addr,    v.daddr);
                check_output({tag, "_dm_mwe"},  32'(mem_bus.we), 32'(v.dwe));
                if (v.dwe) check_output({tag, "_dm_wdata"}, mem_bus.wdata, v.dwdata);
                else       check_output({tag, "_dm_rdata"}, dm_rdata,      v.rdata);
            end
            if (ic_fill_done) done_rel = c;
            p_req   = mem_bus.req;
            p_ack   = mem_bus.ack;
            p_we    = mem_bus.we;
            p_addr  = mem_bus.addr;
            p_wdata = mem_bus.wdata;
            @(posedge CLK);
            #2;
            if (done_rel != 0) ic_miss = 1'b0;
            if (dm_rel != 0) dm_req = 1'b0;
            if (v.dreq && !dm_raised && c >= v.dm_delay) begin
                dm_req    = 1'b1;
                dm_raised = 1'b1;
            end
            finished = (!v.miss || done_rel != 0) && (!v.dreq || dm_rel != 0);
        end
        check_output({tag, "_timeout"}, 32'(finished), 32'd1);
        ic_miss = 1'b0;
        dm_req  = 1'b0;
        #1;
        check_output({tag, "_idle_stall"}, 32'(ic_stall),    32'd0);
        check_output({tag, "_idle_req"},   32'(mem_bus.req), 32'd0);
        check_output({tag, "_fills"}, 32'(fills), v.miss ? 32'd8 : 32'd0);
        if (v.done_rel >= 0) check_output({tag, "_done_cycle"}, 32'(done_rel), 32'(v.done_rel));
        if (v.dm_rel >= 0)   check_output({tag, "_dm_cycle"},   32'(dm_rel),   32'(v.dm_rel));
        if (v.miss && v.dreq) check_output({tag, "_dm_first"}, 32'(dm_rel < done_rel), 32'(v.dm_first));
        if (v.dreq && v.dwe)  check_output({tag, "_stored"},   mem_read(v.daddr), v.dwdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tv [9];
        vec_t rv;
        int   seen;

        //        miss  ic_addr        dreq  dwe   daddr         dwdata         dly lat stray first_idx           done dm  dmfirst rdata
        tv[0] = '{1'b1, 32'h0000_0124, 1'b1, 1'b0, 32'h0000_2000, 32'h0,         0,  1,  1'b0, (CWF ? 3'd1 : 3'd0), 12,  2,  1'b1,  32'h5A5A_85A5};
        tv[1] = '{1'b1, 32'h0000_0124, 1'b0, 1'b0, 32'h0,         32'h0,         0,  1,  1'b0, (CWF ? 3'd1 : 3'd0), 10,  0,  1'b0,  32'h0};
        tv[2] = '{1'b1, 32'h0000_3048, 1'b0, 1'b0, 32'h0,         32'h0,         0,  2,  1'b0, (CWF ? 3'd2 : 3'd0), 18,  0,  1'b0,  32'h0};
        tv[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_2000, 32'h0,         0,  3,  1'b0, 3'd0,                0,   4,  1'b0,  32'h5A5A_85A5};
        tv[4] = '{1'b1, 32'h0000_01FC, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0,  1,  1'b0, (CWF ? 3'd7 : 3'd0), 10,  12, 1'b0,  32'h0};
        tv[5] = '{1'b1, 32'h0000_4010, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         0,  1,  1'b0, (CWF ? 3'd4 : 3'd0), 10,  12, 1'b0,  32'hDEAD_BEEF};
        tv[6] = '{1'b1, 32'h0000_0500, 1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4,  1,  1'b0, 3'd0,                10,  12, 1'b0,  32'h0};
        tv[7] = '{1'b1, 32'h0ABC_DE58, 1'b1, 1'b0, 32'h0000_2004, 32'h0,         0,  0,  1'b1, (CWF ? 3'd6 : 3'd0), -1,  -1, 1'b0,  32'h5A5A_85A1};
        tv[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_1004, 32'h0,         0,  0,  1'b1, 3'd0,                0,   -1, 1'b0,  32'hCAFE_F00D};

        RST      = 1'b1;
        ic_miss  = 1'b0;
        ic_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_all_zero("reset");
        @(posedge CLK);
        #2;
        RST = 1'b0;

        for (int i = 0; i < 9; i++) begin
            $display("[TB] vector %0d", i);
            run_vector(i, tv[i]);
        end
        stray_en = 1'b0;
        lat_mode = 1;

        $display("[TB] reset during burst");
        ic_addr = 32'h0000_0124;
        ic_miss = 1'b1;
        seen    = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge CLK);
            #1;
            if (ic_fill_we) seen++;
            @(posedge CLK);
            #2;
        end
        check_output("abort_acks_seen", 32'(seen), 32'd3);
        RST     = 1'b1;
        ic_miss = 1'b0;
        @(posedge CLK);
        #2;
        @(negedge CLK);
        #1;
        check_all_zero("abort");
        @(posedge CLK);
        #2;
        RST = 1'b0;

        rv = tv[0];
        run_vector(9, rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
